// File: rtl/load_store_unit_if.sv
// Bundles the pipeline request/response handshake and the data-memory bus
// seen by the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] load_data;
    logic        mem_wEn;
    logic [15:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    // The load/store unit itself
    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_err, load_data,
        output mem_wEn, mem_address, mem_write_data
    );

    // The pipeline and memory surrounding it
    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_err, load_data,
        input  mem_wEn, mem_address, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V load/store initiator for a word-wide synchronous data memory; byte and
// halfword stores are done as read-modify-write.
module load_store_unit (
    input  logic                     clk,
    input  logic                     rst_n,
    load_store_unit_if.slave         bus
);

    typedef enum logic [2:0] {IDLE, ACCESS, DATA, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addrLow_q, addrLow_d;
    logic [15:0] wdataLow_q, wdataLow_d;
    logic        memWEn_q, memWEn_d;
    logic [15:0] memAddress_q, memAddress_d;
    logic [31:0] memWriteData_q, memWriteData_d;
    logic [31:0] loadData_q, loadData_d;
    logic        respValid_q, respValid_d;
    logic        respErr_q, respErr_d;

    logic        accept;
    logic        reqIllegal;
    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    logic [31:0] extracted;
    logic [31:0] merged;

    assign accept = bus.req_valid && (state_q == IDLE);

    // Reserved funct3 codes, unsigned stores and misaligned H/W accesses never reach memory
    always_comb begin
        reqIllegal = (bus.req_funct3 == 3'b011)
                  || (bus.req_funct3[2:1] == 2'b11)
                  || (bus.req_store && bus.req_funct3[2])
                  || ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
                  || ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    end

    always_comb begin
        byteLane  = bus.mem_read_data[{addrLow_q, 3'b000} +: 8];
        halfLane  = addrLow_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
        extracted = bus.mem_read_data;
        case (funct3_q)
            3'b000:  extracted = {{24{byteLane[7]}}, byteLane};
            3'b001:  extracted = {{16{halfLane[15]}}, halfLane};
            3'b100:  extracted = {24'b0, byteLane};
            3'b101:  extracted = {16'b0, halfLane};
            default: extracted = bus.mem_read_data;
        endcase
        merged = bus.mem_read_data;
        if (funct3_q[1:0] == 2'b00)
            merged[{addrLow_q, 3'b000} +: 8] = wdataLow_q[7:0];
        else
            merged[{addrLow_q[1], 4'b0000} +: 16] = wdataLow_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            store_q        <= 1'b0;
            funct3_q       <= 3'b000;
            addrLow_q      <= 2'b00;
            wdataLow_q     <= 16'h0000;
            memWEn_q       <= 1'b0;
            memAddress_q   <= 16'h0000;
            memWriteData_q <= 32'h0000_0000;
            loadData_q     <= 32'h0000_0000;
            respValid_q    <= 1'b0;
            respErr_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            store_q        <= store_d;
            funct3_q       <= funct3_d;
            addrLow_q      <= addrLow_d;
            wdataLow_q     <= wdataLow_d;
            memWEn_q       <= memWEn_d;
            memAddress_q   <= memAddress_d;
            memWriteData_q <= memWriteData_d;
            loadData_q     <= loadData_d;
            respValid_q    <= respValid_d;
            respErr_q      <= respErr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = reqIllegal ? RESP : ACCESS;
            ACCESS:  state_d = (store_q && (funct3_q[1:0] == 2'b10)) ? RESP : DATA;
            DATA:    state_d = store_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write enable defaults low so it is only ever high for the single cycle after it is set
    always_comb begin
        store_d        = store_q;
        funct3_d       = funct3_q;
        addrLow_d      = addrLow_q;
        wdataLow_d     = wdataLow_q;
        memWEn_d       = 1'b0;
        memAddress_d   = memAddress_q;
        memWriteData_d = memWriteData_q;
        loadData_d     = loadData_q;
        respErr_d      = respErr_q;
        respValid_d    = (state_d == RESP);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    store_d    = bus.req_store;
                    funct3_d   = bus.req_funct3;
                    addrLow_d  = bus.req_addr[1:0];
                    wdataLow_d = bus.req_wdata[15:0];
                    if (reqIllegal) begin
                        respErr_d  = 1'b1;
                        loadData_d = 32'h0000_0000;
                    end else begin
                        memAddress_d = bus.req_addr;
                        if (bus.req_store && (bus.req_funct3 == 3'b010)) begin
                            memWEn_d       = 1'b1;
                            memWriteData_d = bus.req_wdata;
                        end
                    end
                end
            end
            ACCESS: begin
                if (state_d == RESP) respErr_d = 1'b0;
            end
            DATA: begin
                if (store_q) begin
                    memWEn_d       = 1'b1;
                    memWriteData_d = merged;
                end else begin
                    loadData_d = extracted;
                    respErr_d  = 1'b0;
                end
            end
            WRITE: begin
                respErr_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.req_ready      = (state_q == IDLE);
    assign bus.resp_valid     = respValid_q;
    assign bus.resp_err       = respErr_q;
    assign bus.load_data      = loadData_q;
    assign bus.mem_wEn        = memWEn_q;
    assign bus.mem_address    = memAddress_q;
    assign bus.mem_write_data = memWriteData_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small synchronous-read word memory
// behind it; expected values are hand-computed constants.
module tb_load_store_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [31:0] memArr [0:63];

    load_store_unit_if bus();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word memory: write-enable commits on the edge, read data is the word addressed on the previous edge
    always @(posedge clk) begin
        if (bus.mem_wEn) memArr[bus.mem_address[7:2]] <= bus.mem_write_data;
        bus.mem_read_data <= memArr[bus.mem_address[7:2]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request on a falling edge, returns 1 time unit after the accept edge
    task automatic applyStimulus(input logic st, input logic [2:0] f3,
                                 input logic [15:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        checkOutput("readyBeforeReq", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_store  = ~st;
        bus.req_funct3 = 3'b111;
        bus.req_addr   = 16'hFFFF;
        bus.req_wdata  = 32'hCAFE_F00D;
    endtask

    task automatic runTxn(input string tag, input int expLat, input logic expErr,
                          input logic checkLoad, input logic [31:0] expLoad,
                          input int expWrites, input logic [15:0] expWAddr);
        int          lat;
        int          respCycles;
        int          writes;
        logic [15:0] wAddr;
        logic [31:0] gotLoad;
        logic        gotErr;
        lat = -1; respCycles = 0; writes = 0;
        wAddr = 16'h0; gotLoad = 32'h0; gotErr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.mem_wEn) begin
                writes++;
                wAddr = bus.mem_address;
            end
            if (bus.resp_valid) begin
                respCycles++;
                if (lat < 0) begin
                    lat     = k;
                    gotErr  = bus.resp_err;
                    gotLoad = bus.load_data;
                end
            end
        end
        checkOutput({tag, "/latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "/respCycles"}, 32'(respCycles), 32'd1);
        checkOutput({tag, "/err"}, 32'(gotErr), 32'(expErr));
        checkOutput({tag, "/writes"}, 32'(writes), 32'(expWrites));
        if (checkLoad) checkOutput({tag, "/loadData"}, gotLoad, expLoad);
        if (expWrites > 0) checkOutput({tag, "/wAddr"}, 32'(wAddr), 32'(expWAddr));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) memArr[i] = 32'h0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 16'h0;
        bus.req_wdata  = 32'h0;
        #12;
        checkOutput("rst/ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst/respValid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst/wEn", 32'(bus.mem_wEn), 32'd0);
        checkOutput("rst/loadData", bus.load_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 3'b010, 16'h0010, 32'hDEAD_BEEF);
        runTxn("SW", 1, 1'b0, 1'b0, 32'h0, 1, 16'h0010);
        checkOutput("SW/mem", memArr[4], 32'hDEAD_BEEF);
        applyStimulus(1'b0, 3'b010, 16'h0010, 32'h0);
        runTxn("LW1", 2, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, 16'h0);

        applyStimulus(1'b1, 3'b000, 16'h0013, 32'h1234_56A5);
        runTxn("SB", 3, 1'b0, 1'b0, 32'h0, 1, 16'h0013);
        checkOutput("SB/mem", memArr[4], 32'hA5AD_BEEF);
        applyStimulus(1'b0, 3'b000, 16'h0013, 32'h0);
        runTxn("LB", 2, 1'b0, 1'b1, 32'hFFFF_FFA5, 0, 16'h0);
        applyStimulus(1'b0, 3'b100, 16'h0013, 32'h0);
        runTxn("LBU", 2, 1'b0, 1'b1, 32'h0000_00A5, 0, 16'h0);

        applyStimulus(1'b1, 3'b001, 16'h0012, 32'h1234_8001);
        runTxn("SH", 3, 1'b0, 1'b0, 32'h0, 1, 16'h0012);
        checkOutput("SH/mem", memArr[4], 32'h8001_BEEF);
        applyStimulus(1'b0, 3'b001, 16'h0012, 32'h0);
        runTxn("LH12", 2, 1'b0, 1'b1, 32'hFFFF_8001, 0, 16'h0);
        applyStimulus(1'b0, 3'b101, 16'h0012, 32'h0);
        runTxn("LHU12", 2, 1'b0, 1'b1, 32'h0000_8001, 0, 16'h0);
        applyStimulus(1'b0, 3'b001, 16'h0010, 32'h0);
        runTxn("LH10", 2, 1'b0, 1'b1, 32'hFFFF_BEEF, 0, 16'h0);

        applyStimulus(1'b0, 3'b010, 16'h0006, 32'h0);
        runTxn("illLW6", 0, 1'b1, 1'b1, 32'h0, 0, 16'h0);
        applyStimulus(1'b1, 3'b001, 16'h0011, 32'h5555_5555);
        runTxn("illSH11", 0, 1'b1, 1'b1, 32'h0, 0, 16'h0);
        applyStimulus(1'b0, 3'b011, 16'h0010, 32'h0);
        runTxn("illF3", 0, 1'b1, 1'b1, 32'h0, 0, 16'h0);
        checkOutput("ill/mem", memArr[4], 32'h8001_BEEF);
        applyStimulus(1'b0, 3'b010, 16'h0010, 32'h0);
        runTxn("LW2", 2, 1'b0, 1'b1, 32'h8001_BEEF, 0, 16'h0);

        // Reset in the middle of the ACCESS cycle of a word store
        applyStimulus(1'b1, 3'b010, 16'h0020, 32'h1111_1111);
        checkOutput("rstAcc/wEnBefore", 32'(bus.mem_wEn), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstAcc/wEn", 32'(bus.mem_wEn), 32'd0);
        checkOutput("rstAcc/addr", 32'(bus.mem_address), 32'h0);
        checkOutput("rstAcc/wdata", bus.mem_write_data, 32'h0);
        checkOutput("rstAcc/loadData", bus.load_data, 32'h0);
        checkOutput("rstAcc/respValid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rstAcc/respErr", 32'(bus.resp_err), 32'd0);
        checkOutput("rstAcc/ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rstAcc/readyAfter", 32'(bus.req_ready), 32'd1);
        checkOutput("rstAcc/mem", memArr[8], 32'h0);

        // Reset during the WRITE cycle of a byte store must cancel the write
        applyStimulus(1'b1, 3'b000, 16'h0010, 32'h0000_00FF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("rstWr/wEnBefore", 32'(bus.mem_wEn), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstWr/wEn", 32'(bus.mem_wEn), 32'd0);
        checkOutput("rstWr/respValid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rstWr/mem", memArr[4], 32'h8001_BEEF);
        applyStimulus(1'b0, 3'b010, 16'h0010, 32'h0);
        runTxn("LW3", 2, 1'b0, 1'b1, 32'h8001_BEEF, 0, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
